// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - RAW/mem-wait stall generator with EX/MEM/WB destination scoreboard
// Optional registered EX-operand forwarding selects when HAZARD_FWD_EN is defined.
module hazard_stall_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] INS,
    input  logic        ins_valid,
    input  logic        mem_wait,
    output logic        Stall,
    output logic [1:0]  FwdA,
    output logic [1:0]  FwdB,
    output logic [15:0] stall_cnt
);

    typedef struct packed {
        logic       vld;
        logic [4:0] dst;
        logic       ld;
    } sb_entry_t;

    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

`ifdef HAZARD_FWD_EN
    // Only a load still in EX forces a stall; everything else is forwarded.
    localparam logic [2:0] STALL_ANY_MASK  = 3'b000;
    localparam logic [2:0] STALL_LOAD_MASK = 3'b001;
`else
    localparam logic [2:0] STALL_ANY_MASK  = 3'b011;
    localparam logic [2:0] STALL_LOAD_MASK = 3'b000;
`endif

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        use_rs;
    logic        use_rt;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic        is_load;
    logic        src_a_vld;
    logic        src_b_vld;
    logic        dest_vld;

    sb_entry_t   sb_q [3];
    sb_entry_t   sb_d [3];
    logic [2:0]  hit_a;
    logic [2:0]  hit_b;
    logic [2:0]  ld_vec;
    logic        hazard;

    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    assign op = INS[31:26];
    assign fn = INS[5:0];
    assign rs = INS[25:21];
    assign rt = INS[20:16];
    assign rd = INS[15:11];

    always_comb begin
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        wr_en   = 1'b0;
        wr_reg  = 5'd0;
        is_load = 1'b0;
        case (op)
            6'h00: begin
                if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) begin
                    use_rt = 1'b1;
                    wr_en  = 1'b1;
                    wr_reg = rd;
                end else if (fn == 6'h08) begin
                    use_rs = 1'b1;
                end else begin
                    use_rs = 1'b1;
                    use_rt = 1'b1;
                    wr_en  = 1'b1;
                    wr_reg = rd;
                end
            end
            6'h03: begin
                wr_en  = 1'b1;
                wr_reg = 5'd31;
            end
            6'h04, 6'h05: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            6'h06, 6'h07: begin
                use_rs = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                use_rs = 1'b1;
                wr_en  = 1'b1;
                wr_reg = rt;
            end
            6'h0F: begin
                wr_en  = 1'b1;
                wr_reg = rt;
            end
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25: begin
                use_rs  = 1'b1;
                wr_en   = 1'b1;
                wr_reg  = rt;
                is_load = 1'b1;
            end
            6'h28, 6'h29, 6'h2A, 6'h2B: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            default: begin
                use_rs = 1'b0;
            end
        endcase
    end

    // $0 is hardwired, so it can neither create nor consume a dependency.
    assign src_a_vld = ins_valid & use_rs & (rs != 5'd0);
    assign src_b_vld = ins_valid & use_rt & (rt != 5'd0);
    assign dest_vld  = wr_en & (wr_reg != 5'd0);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            hit_a[i]  = sb_q[i].vld & src_a_vld & (sb_q[i].dst == rs);
            hit_b[i]  = sb_q[i].vld & src_b_vld & (sb_q[i].dst == rt);
            ld_vec[i] = sb_q[i].ld;
        end
    end

    assign hazard = (|((hit_a | hit_b) & STALL_ANY_MASK))
                  | (|((hit_a | hit_b) & ld_vec & STALL_LOAD_MASK));
    assign Stall  = mem_wait | hazard;

    always_comb begin
        sb_d[EX]  = sb_q[EX];
        sb_d[MEM] = sb_q[MEM];
        sb_d[WB]  = sb_q[WB];
        if (!mem_wait) begin
            sb_d[WB]  = sb_q[MEM];
            sb_d[MEM] = sb_q[EX];
            if (ins_valid && !Stall) begin
                sb_d[EX].vld = dest_vld;
                sb_d[EX].dst = wr_reg;
                sb_d[EX].ld  = is_load & dest_vld;
            end else begin
                sb_d[EX] = '0;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                sb_q[i] <= '0;
            end
            stall_cnt_q <= 16'd0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

`ifdef HAZARD_FWD_EN
    logic [1:0] fwd_a_q;
    logic [1:0] fwd_a_d;
    logic [1:0] fwd_b_q;
    logic [1:0] fwd_b_d;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    // The younger EX producer takes priority over MEM.
    always_comb begin
        sel_a = 2'b00;
        sel_b = 2'b00;
        if (hit_a[EX]) begin
            sel_a = 2'b01;
        end else if (hit_a[MEM]) begin
            sel_a = 2'b10;
        end
        if (hit_b[EX]) begin
            sel_b = 2'b01;
        end else if (hit_b[MEM]) begin
            sel_b = 2'b10;
        end
    end

    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!mem_wait) begin
            if (ins_valid && !Stall) begin
                fwd_a_d = sel_a;
                fwd_b_d = sel_b;
            end else begin
                fwd_a_d = 2'b00;
                fwd_b_d = 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign FwdA = fwd_a_q;
    assign FwdB = fwd_b_q;
`else
    assign FwdA = 2'b00;
    assign FwdB = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - randomized and directed bench for hazard_stall_unit
module tb_hazard_stall_unit;

`ifdef HAZARD_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] INS;
    logic        ins_valid;
    logic        mem_wait;
    logic        Stall;
    logic [1:0]  FwdA;
    logic [1:0]  FwdB;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_stall_unit dut (
        .clk       (clk),
        .reset     (reset),
        .INS       (INS),
        .ins_valid (ins_valid),
        .mem_wait  (mem_wait),
        .Stall     (Stall),
        .FwdA      (FwdA),
        .FwdB      (FwdB),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: per-register "advance index at which the latest producer entered EX".
    int         adv;
    int         wt [32];
    bit         wv [32];
    bit         wl [32];
    logic [1:0] mfa;
    logic [1:0] mfb;
    int         mcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void dec(input logic [31:0] ins, output bit ua, output bit ub,
                                output bit ld, output int dst);
        int op;
        int fn;
        op  = int'(ins[31:26]);
        fn  = int'(ins[5:0]);
        ua  = 0;
        ub  = 0;
        ld  = 0;
        dst = 0;
        if (op == 0) begin
            if (fn == 0 || fn == 2 || fn == 3) begin
                ub = 1; dst = int'(ins[15:11]);
            end else if (fn == 8) begin
                ua = 1;
            end else begin
                ua = 1; ub = 1; dst = int'(ins[15:11]);
            end
        end else if (op == 3) dst = 31;
        else if (op == 4 || op == 5) begin ua = 1; ub = 1; end
        else if (op == 6 || op == 7) ua = 1;
        else if (op >= 8 && op <= 14) begin ua = 1; dst = int'(ins[20:16]); end
        else if (op == 15) dst = int'(ins[20:16]);
        else if (op >= 32 && op <= 37) begin ua = 1; ld = 1; dst = int'(ins[20:16]); end
        else if (op >= 40 && op <= 43) begin ua = 1; ub = 1; end
    endfunction

    function automatic bit mhaz(input bit used, input int r);
        int d;
        if (!used || r == 0 || !wv[r]) return 0;
        d = adv - wt[r];
        if (FWD == 1) return (d == 0) && wl[r];
        return d <= 1;
    endfunction

    function automatic logic [1:0] msel(input bit used, input int r);
        int d;
        if (FWD == 0 || !used || r == 0 || !wv[r]) return 2'b00;
        d = adv - wt[r];
        if (d == 0) return 2'b01;
        if (d == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        adv  = 0;
        mfa  = 2'b00;
        mfb  = 2'b00;
        mcnt = 0;
        for (int i = 0; i < 32; i++) begin
            wv[i] = 0; wl[i] = 0; wt[i] = 0;
        end
    endtask

    task automatic step(input logic [31:0] ins, input bit v, input bit mw, input bit rst,
                        output bit st);
        bit ua, ub, ld;
        int dst, rs, rt;
        logic [1:0] sa, sb;
        reset = rst; INS = ins; ins_valid = v; mem_wait = mw;
        dec(ins, ua, ub, ld, dst);
        ua = ua & v;
        ub = ub & v;
        rs = int'(ins[25:21]);
        rt = int'(ins[20:16]);
        st = mw | mhaz(ua, rs) | mhaz(ub, rt);
        sa = msel(ua, rs);
        sb = msel(ub, rt);
        @(negedge clk);
        chk("stall", 32'(Stall), 32'(st));
        chk("fwda", 32'(FwdA), 32'(mfa));
        chk("fwdb", 32'(FwdB), 32'(mfb));
        chk("stall_cnt", 32'(stall_cnt), 32'(mcnt));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (st && mcnt < 65535) mcnt++;
            if (!mw) begin
                adv++;
                if (v && !st) begin
                    mfa = sa;
                    mfb = sb;
                    if (dst != 0) begin
                        wv[dst] = 1; wt[dst] = adv; wl[dst] = ld;
                    end
                end else begin
                    mfa = 2'b00;
                    mfb = 2'b00;
                end
            end
        end
        #1;
    endtask

    task automatic run_ins(input logic [31:0] ins);
        bit st;
        int n;
        n = 0;
        do begin
            step(ins, 1, 0, 0, st);
            n++;
        end while (st && n < 20);
        if (st) chk("run_timeout", 32'(n), 32'(0));
    endtask

    task automatic do_reset();
        bit st;
        step(32'h0, 1, 0, 1, st);
    endtask

    function automatic logic [4:0] rreg();
        int x;
        x = $urandom_range(0, 8);
        return (x == 8) ? 5'd31 : 5'(x);
    endfunction

    function automatic logic [31:0] rnd_ins();
        logic [4:0] a, b, c;
        a = rreg(); b = rreg(); c = rreg();
        case ($urandom_range(0, 11))
            0:  return {6'h00, a, b, c, 5'd0, 6'h20};
            1:  return {6'h00, a, b, c, 5'd3, 6'h00};
            2:  return {6'h00, a, b, c, 5'd0, 6'h08};
            3:  return {6'h23, a, b, 16'h0004};
            4:  return {6'h2B, a, b, 16'h0008};
            5:  return {6'h04, a, b, 16'h0002};
            6:  return {6'h06, a, b, 16'h0002};
            7:  return {6'h08, a, b, 16'h0005};
            8:  return {6'h0F, a, b, 16'h1234};
            9:  return {6'h02, 26'h0000100};
            10: return {6'h03, 26'h0000200};
            default: return {6'h3F, a, b, c, 11'h0};
        endcase
    endfunction

    initial begin
        bit st;
        logic [31:0] cur;
        model_reset();
        reset = 1; INS = 32'h0; ins_valid = 1; mem_wait = 0;
        @(posedge clk);
        #1;

        // Reset state and nop stream
        do_reset();
        chk("rst_stall", 32'(Stall), 32'(0));
        chk("rst_fwda", 32'(FwdA), 32'(0));
        chk("rst_fwdb", 32'(FwdB), 32'(0));
        chk("rst_cnt", 32'(stall_cnt), 32'(0));
        for (int i = 0; i < 5; i++) run_ins(32'h0);
        chk("nop_cnt", 32'(stall_cnt), 32'(0));

        // Load-use
        do_reset();
        run_ins(32'h8C280000);
        run_ins(32'h01084820);
        chk("lwadd_fwda", 32'(FwdA), FWD ? 32'd2 : 32'd0);
        chk("lwadd_fwdb", 32'(FwdB), FWD ? 32'd2 : 32'd0);
        chk("lwadd_cnt", 32'(stall_cnt), FWD ? 32'd1 : 32'd2);
        for (int i = 0; i < 3; i++) run_ins(32'h0);

        // ALU-to-ALU
        do_reset();
        run_ins(32'h00224020);
        run_ins(32'h01035022);
        chk("addsub_fwda", 32'(FwdA), FWD ? 32'd1 : 32'd0);
        chk("addsub_fwdb", 32'(FwdB), 32'd0);
        chk("addsub_cnt", 32'(stall_cnt), FWD ? 32'd0 : 32'd2);

        // $0 destination never creates a hazard
        do_reset();
        run_ins(32'h20200005);
        run_ins(32'h00004820);
        chk("zero_cnt", 32'(stall_cnt), 32'd0);

        // mem_wait overlapping a pending load-use hazard
        do_reset();
        run_ins(32'h8C280000);
        for (int i = 0; i < 3; i++) step(32'h01084820, 1, 1, 0, st);
        run_ins(32'h01084820);
        chk("wait_haz_cnt", 32'(stall_cnt), FWD ? 32'd4 : 32'd5);
        for (int i = 0; i < 3; i++) run_ins(32'h0);

        // Randomized traffic with occasional reset
        do_reset();
        cur = rnd_ins();
        for (int i = 0; i < 4000; i++) begin
            step(cur, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 499) == 0, st);
            if (!st) cur = rnd_ins();
        end

        // Counter saturation
        do_reset();
        for (int i = 0; i < 70000; i++) step(32'h0, 1, 1, 0, st);
        chk("sat_cnt", 32'(stall_cnt), 32'hFFFF);
        step(32'h0, 1, 1, 0, st);
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        do_reset();
        chk("sat_reset", 32'(stall_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
